bus_arbiter: RTL and testbench

Shares the core's single external memory bus between the instruction-fetch port (IF) and the data port (MEM). It issues one transaction at a time: a pending data access always wins over a fetch. Each port's result is held in a buffer until the pipeline consumes it. The block drives the IF and MEM bits of the `stallreq` vector seen by the pipeline controller, and honours that controller's `stall` and `flush` vectors.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/bus_port_buf.sv | 48 ++++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the IF/MEM external bus arbiter.
// The stall-vector indices must match the pipeline controller's numbering.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_MEM = 3;

endpackage

// File: rtl/bus_port_buf.sv
// Per-port result buffer: buffer-valid flag, held read data, and the drop flag
// that discards a transaction flushed while it was on the bus.
module bus_port_buf
  import bus_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          consume,
  input  logic          flush,
  input  logic          capture,
  input  logic          in_flight,
  input  logic [DW-1:0] cap_data,
  output logic          bv,
  output logic [DW-1:0] rdata
);

  logic drop;
  logic keep;

  // A flush landing on the ack edge discards the data just like a pending drop.
  assign keep = capture & ~drop & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bv    <= 1'b0;
      drop  <= 1'b0;
      rdata <= '0;
    end else begin
      if (flush)
        bv <= 1'b0;
      else if (keep)
        bv <= 1'b1;
      else if (consume)
        bv <= 1'b0;

      if (capture)
        drop <= 1'b0;
      else if (flush && in_flight)
        drop <= 1'b1;

      if (keep)
        rdata <= cap_data;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single external bus shared by instruction fetch and data access; data wins.
// One transaction at a time, results parked in per-port buffers.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_stallreq,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            d_en,
  input  logic [DW/8-1:0] d_wen,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stallreq,
  input  logic            d_stall,
  input  logic            d_flush,
  output logic            bus_req,
  output logic [DW/8-1:0] bus_wen,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata
);

  arb_state_e      state_q, state_d;
  logic            bus_req_d;
  logic [DW/8-1:0] bus_wen_d;
  logic [AW-1:0]   bus_addr_d;
  logic [DW-1:0]   bus_wdata_d;
  logic            i_bv, d_bv;
  logic            i_pend, d_pend;
  logic            i_busy, d_busy;

  assign i_busy     = (state_q == IBUSY);
  assign d_busy     = (state_q == DBUSY);
  assign i_stallreq = i_en & ~i_bv;
  assign d_stallreq = d_en & ~d_bv;
  // Nothing goes out on the bus for a port that is being flushed this cycle.
  assign i_pend     = i_en & ~i_bv & ~i_flush;
  assign d_pend     = d_en & ~d_bv & ~d_flush;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req;
    bus_wen_d   = bus_wen;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d     = DBUSY;
          bus_req_d   = 1'b1;
          bus_wen_d   = d_wen;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
        end else if (i_pend) begin
          state_d     = IBUSY;
          bus_req_d   = 1'b1;
          bus_wen_d   = '0;
          bus_addr_d  = i_addr;
          bus_wdata_d = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_req   <= 1'b0;
      bus_wen   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      bus_req   <= bus_req_d;
      bus_wen   <= bus_wen_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
    end
  end

  bus_port_buf #(.DW(DW)) u_i_buf (
    .clk       (clk),
    .rst       (rst),
    .consume   (~i_stall),
    .flush     (i_flush),
    .capture   (bus_ack & i_busy),
    .in_flight (i_busy),
    .cap_data  (bus_rdata),
    .bv        (i_bv),
    .rdata     (i_rdata)
  );

  bus_port_buf #(.DW(DW)) u_d_buf (
    .clk       (clk),
    .rst       (rst),
    .consume   (~d_stall),
    .flush     (d_flush),
    .capture   (bus_ack & d_busy),
    .in_flight (d_busy),
    .cap_data  (bus_rdata),
    .bv        (d_bv),
    .rdata     (d_rdata)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a scoreboard queue holds the bus transaction
// each step expects, and a small slave model pops and checks it when issued.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_stall, i_flush;
  logic [31:0] i_addr, i_rdata;
  logic        i_stallreq;
  logic        d_en, d_stall, d_flush;
  logic [3:0]  d_wen;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_stallreq;
  logic        bus_req, bus_ack;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cyc, ack_cyc, prev_ack;
  logic [31:0] held;

  bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_stallreq(i_stallreq),
    .i_stall(i_stall), .i_flush(i_flush),
    .d_en(d_en), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stallreq(d_stallreq), .d_stall(d_stall), .d_flush(d_flush),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                      input logic [31:0] rd);
    txn_t t;
    t.addr = a; t.wen = w; t.wdata = wd; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  // Slave: wait for bus_req, check it against the scoreboard, hold for 'delay'
  // cycles, optionally pulse the owner's flush at hold cycle 'flush_at', then ack.
  // Returns at the cycle after the ack (posedge + 1).
  task automatic serve(input int delay, input int flush_at, input bit is_d);
    txn_t t;
    int   n;
    n = 0;
    @(negedge clk);
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", bus_req, 1'b1);
    if (bus_req !== 1'b1) return;
    req_cyc = cyc;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) @(negedge clk);
      chk("bus_req_hold", bus_req, 1'b1);
      chk("bus_addr", bus_addr, t.addr);
      chk("bus_wen", 32'(bus_wen), 32'(t.wen));
      chk("bus_wdata", bus_wdata, t.wdata);
      chk("owner_stallreq", is_d ? d_stallreq : i_stallreq, 1'b1);
      if (k == flush_at) begin
        if (is_d) d_flush = 1'b1;
        else i_flush = 1'b1;
      end
      if (k == delay) begin
        bus_ack   = 1'b1;
        bus_rdata = t.rdata;
        ack_cyc   = cyc;
      end
      tick();
      i_flush = 1'b0;
      d_flush = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_en = 0; i_addr = 0; i_stall = 0; i_flush = 0;
    d_en = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_stall = 0; d_flush = 0;
    bus_ack = 0; bus_rdata = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_stallreq", i_stallreq, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // single fetch, minimum latency
    i_en = 1; i_addr = 32'hBFC0_0000;
    push(32'hBFC0_0000, 4'h0, 32'h0, 32'h3C08_0001);
    @(negedge clk);
    chk("c0_i_stallreq", i_stallreq, 1'b1);
    chk("c0_bus_req", bus_req, 1'b0);
    serve(0, -1, 0);
    @(negedge clk);
    chk("c2_bus_req", bus_req, 1'b0);
    chk("c2_i_stallreq", i_stallreq, 1'b0);
    chk("c2_i_rdata", i_rdata, 32'h3C08_0001);
    tick();
    i_en = 0;
    @(negedge clk);
    chk("c3_bus_req", bus_req, 1'b0);
    tick();

    // conflict: data access goes first
    i_en = 1; i_addr = 32'hBFC0_0008;
    d_en = 1; d_wen = 4'h0; d_addr = 32'h8000_0010; d_wdata = 32'h0;
    push(32'h8000_0010, 4'h0, 32'h0, 32'hCAFE_F00D);
    push(32'hBFC0_0008, 4'h0, 32'h0, 32'h1111_1111);
    @(negedge clk);
    chk("cf_d_stallreq0", d_stallreq, 1'b1);
    chk("cf_i_stallreq0", i_stallreq, 1'b1);
    serve(0, -1, 1);
    @(negedge clk);
    chk("cf_d_stallreq", d_stallreq, 1'b0);
    chk("cf_i_stallreq", i_stallreq, 1'b1);
    chk("cf_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("cf_gap_bus_req", bus_req, 1'b0);
    d_en = 0;
    prev_ack = ack_cyc;
    tick();
    serve(0, -1, 0);
    chk("cf_i_req_gap", 32'(req_cyc - prev_ack), 2);
    @(negedge clk);
    chk("cf_i_rdata", i_rdata, 32'h1111_1111);
    i_en = 0;
    tick();

    // hold: result parked while IF is stalled
    i_stall = 1; i_en = 1; i_addr = 32'hBFC0_0004;
    push(32'hBFC0_0004, 4'h0, 32'h0, 32'h2409_0002);
    serve(0, -1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_bus_req", bus_req, 1'b0);
      chk("hold_i_stallreq", i_stallreq, 1'b0);
      chk("hold_i_rdata", i_rdata, 32'h2409_0002);
      tick();
    end
    i_stall = 0;
    @(negedge clk);
    chk("hold_release_bv", i_stallreq, 1'b0);
    tick();
    @(negedge clk);
    chk("hold_consumed", i_stallreq, 1'b1);
    i_en = 0;
    tick();

    // flush while the fetch is on the bus; ack 4 cycles later
    i_en = 1; i_addr = 32'hBFC0_0010;
    push(32'hBFC0_0010, 4'h0, 32'h0, 32'h0000_DEAD);
    tick();
    i_addr = 32'hBFC0_0100;
    serve(4, 0, 0);
    @(negedge clk);
    chk("fl_i_stallreq", i_stallreq, 1'b1);
    chk("fl_i_rdata", i_rdata, 32'h2409_0002);
    push(32'hBFC0_0100, 4'h0, 32'h0, 32'h0000_5555);
    prev_ack = ack_cyc;
    tick();
    serve(0, -1, 0);
    chk("fl_refetch_gap", 32'(req_cyc - prev_ack), 2);
    @(negedge clk);
    chk("fl_i_rdata_new", i_rdata, 32'h0000_5555);
    i_en = 0;
    tick();

    // flush on the very ack edge
    i_en = 1; i_addr = 32'hBFC0_0200;
    push(32'hBFC0_0200, 4'h0, 32'h0, 32'h7777_7777);
    serve(2, 2, 0);
    @(negedge clk);
    chk("fa_i_stallreq", i_stallreq, 1'b1);
    chk("fa_i_rdata", i_rdata, 32'h0000_5555);
    i_en = 0;
    tick();

    // store with a slow slave
    d_en = 1; d_wen = 4'b0011; d_addr = 32'h8000_0020; d_wdata = 32'h0000_1234;
    push(32'h8000_0020, 4'b0011, 32'h0000_1234, 32'h0);
    serve(5, -1, 1);
    @(negedge clk);
    chk("st_d_stallreq", d_stallreq, 1'b0);
    chk("st_d_rdata", d_rdata, 32'h0);
    d_en = 0; d_wen = 0;
    tick();

    // reset during a data transaction
    d_en = 1; d_addr = 32'h8000_0030; d_wdata = 32'h0;
    push(32'h8000_0030, 4'h0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    chk("rm_bus_req", bus_req, 1'b1);
    chk("rm_bus_addr", bus_addr, exp_q.pop_front().addr);
    held = i_rdata;
    chk("rm_i_rdata_pre", held, 32'h0000_5555);
    rst = 1'b1;
    #1;
    chk("rm_async_bus_req", bus_req, 1'b0);
    chk("rm_async_i_rdata", i_rdata, 32'h0);
    chk("rm_state", 32'(dut.state_q), 32'(IDLE));
    d_en = 0;
    tick();
    rst = 1'b0;
    tick();
    d_en = 1; d_addr = 32'h8000_0040;
    push(32'h8000_0040, 4'h0, 32'h0, 32'h0BAD_BEEF);
    serve(1, -1, 1);
    @(negedge clk);
    chk("rm_after_d_rdata", d_rdata, 32'h0BAD_BEEF);
    chk("rm_after_d_stallreq", d_stallreq, 1'b0);
    d_en = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
